// File: rtl/gb_bus_pkg.sv
// Shared bus definitions: DMA engine states and the memory-map constants
// used by the CPU/memory bus interposer.
package gb_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] DEST_BASE    = 16'hFE00;
    localparam logic [15:0] OAM_END      = 16'hFE9F;
    localparam logic [7:0]  OPEN_BUS     = 8'hFF;

endpackage

// File: rtl/oam_dma_bus.sv
// Bus interposer between the CPU core and the shared memory bus.
// Passes CPU cycles straight through while idle; while an OAM DMA is
// running it copies LENGTH bytes from {srcHi,8'h00} to DEST_BASE and
// fences the CPU off (reads see open bus, writes are dropped), except
// for the DMA register itself which stays readable and writable.
module oam_dma_bus
    import gb_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = gb_bus_pkg::DMA_REG_ADDR,
    parameter logic [15:0] DEST_BASE    = gb_bus_pkg::DEST_BASE,
    parameter int unsigned LENGTH       = 160,
    parameter int unsigned START_DELAY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpuAddress,
    input  logic [7:0]  cpuDataOut,
    input  logic        cpuWriteEnable,
    output logic [7:0]  cpuDataIn,
    output logic [15:0] memAddress,
    output logic [7:0]  memDataOut,
    input  logic [7:0]  memDataIn,
    output logic        memWriteEnable,
    output logic        dmaActive
);

    localparam int unsigned IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int unsigned DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LENGTH - 1);
    localparam logic [DLY_W-1:0] LAST_DLY  = DLY_W'(START_DELAY - 1);

    dma_state_t       state;
    dma_state_t       stateNext;
    logic [IDX_W-1:0] index;
    logic [DLY_W-1:0] delayCnt;
    logic [7:0]       srcHi;
    logic             cpuBlocked;
    logic             regReadPending;

    logic             regHit;
    logic             trigger;

    assign regHit    = (cpuAddress == DMA_REG_ADDR);
    // A write to the DMA register starts (or restarts) a transfer in any state.
    assign trigger   = regHit && cpuWriteEnable;
    assign dmaActive = (state != IDLE);

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Source page and byte index; a trigger wins over the WRITE increment,
    // so a restart landing on a WRITE still lets that write complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srcHi <= '0;
            index <= '0;
        end else if (trigger) begin
            srcHi <= cpuDataOut;
            index <= '0;
        end else if (state == WRITE) begin
            index <= index + 1'b1;
        end
    end

    // Counts idle cycles spent in START before the first read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delayCnt <= '0;
        end else if (state == START && !trigger) begin
            delayCnt <= delayCnt + 1'b1;
        end else begin
            delayCnt <= '0;
        end
    end

    // Read-return qualifiers, registered to line up with memory read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpuBlocked     <= 1'b0;
            regReadPending <= 1'b0;
        end else begin
            cpuBlocked     <= dmaActive && !cpuWriteEnable;
            regReadPending <= regHit && !cpuWriteEnable;
        end
    end

    // Next-state logic; a trigger overrides every other transition.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = IDLE;
            START:   if (delayCnt == LAST_DLY) stateNext = READ;
            READ:    stateNext = WRITE;
            WRITE:   stateNext = (index < LAST_IDX) ? READ : IDLE;
            default: stateNext = IDLE;
        endcase
        if (trigger) begin
            stateNext = START;
        end
    end

    // Memory bus drive: CPU pass-through in IDLE, DMA source/destination otherwise.
    always_comb begin
        memAddress     = cpuAddress;
        memDataOut     = cpuDataOut;
        memWriteEnable = 1'b0;
        case (state)
            IDLE: begin
                memWriteEnable = cpuWriteEnable;
            end
            START: begin
                memWriteEnable = 1'b0;
            end
            READ: begin
                memAddress     = {srcHi, 8'(index)};
                memWriteEnable = 1'b0;
            end
            WRITE: begin
                memAddress     = DEST_BASE + 16'(index);
                memDataOut     = memDataIn;
                memWriteEnable = 1'b1;
            end
            default: begin
                memWriteEnable = 1'b0;
            end
        endcase
    end

    // CPU read data: register readback, then open bus while fenced, then memory.
    always_comb begin
        cpuDataIn = memDataIn;
        if (regReadPending) begin
            cpuDataIn = srcHi;
        end else if (cpuBlocked) begin
            cpuDataIn = OPEN_BUS;
        end
    end

endmodule

// File: tb/tb_oam_dma_bus.sv
// Directed testbench for oam_dma_bus with a 64 KiB registered-read memory.
module tb_oam_dma_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpuAddress;
    logic [7:0]  cpuDataOut;
    logic        cpuWriteEnable;
    logic [7:0]  cpuDataIn;
    logic [15:0] memAddress;
    logic [7:0]  memDataOut;
    logic [7:0]  memDataIn;
    logic        memWriteEnable;
    logic        dmaActive;

    logic [7:0]  mem [0:65535];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    oam_dma_bus #(
        .DMA_REG_ADDR(16'hFF46),
        .DEST_BASE(16'hFE00),
        .LENGTH(160),
        .START_DELAY(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpuAddress(cpuAddress),
        .cpuDataOut(cpuDataOut),
        .cpuWriteEnable(cpuWriteEnable),
        .cpuDataIn(cpuDataIn),
        .memAddress(memAddress),
        .memDataOut(memDataOut),
        .memDataIn(memDataIn),
        .memWriteEnable(memWriteEnable),
        .dmaActive(dmaActive)
    );

    // Memory: 1-cycle registered read. 0xFF46 is an I/O register, not RAM,
    // so writes there do not land in the array.
    always @(posedge clk) begin
        if (memWriteEnable === 1'b1 && memAddress != 16'hFF46)
            mem[memAddress] <= memDataOut;
        memDataIn <= mem[memAddress];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cpuAddress     = 16'h0000;
        cpuDataOut     = 8'h00;
        cpuWriteEnable = 1'b0;
    endtask

    task automatic cpu_trigger(input logic [7:0] page);
        cpuAddress     = 16'hFF46;
        cpuDataOut     = page;
        cpuWriteEnable = 1'b1;
        step();
        idle_bus();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (dmaActive === 1'b1 && n < 2000) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        cpuAddress     = 16'h1234;
        cpuDataOut     = 8'h00;
        cpuWriteEnable = 1'b0;
        #3;
        checks++;
        if (dmaActive !== 1'b0) begin
            errors++; $display("FAIL reset_dmaActive got %b expected 0", dmaActive);
        end
        checks++;
        if (memWriteEnable !== 1'b0) begin
            errors++; $display("FAIL reset_memWE got %b expected 0", memWriteEnable);
        end
        checks++;
        if (memAddress !== 16'h1234) begin
            errors++; $display("FAIL reset_passthru_addr got %04h expected 1234", memAddress);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        cpuAddress = 16'hFF46;
        step();
        idle_bus();
        checks++;
        if (cpuDataIn !== 8'h00) begin
            errors++; $display("FAIL reset_srcHi_readback got %02h expected 00", cpuDataIn);
        end
    endtask

    task automatic test_pass_through();
        cpuAddress     = 16'hC123;
        cpuDataOut     = 8'hA5;
        cpuWriteEnable = 1'b1;
        #1;
        checks++;
        if (memWriteEnable !== 1'b1 || memAddress !== 16'hC123 || memDataOut !== 8'hA5) begin
            errors++;
            $display("FAIL pass_write got we=%b addr=%04h data=%02h expected we=1 addr=C123 data=A5",
                     memWriteEnable, memAddress, memDataOut);
        end
        step();
        cpuWriteEnable = 1'b0;
        step();
        idle_bus();
        checks++;
        if (cpuDataIn !== 8'hA5) begin
            errors++; $display("FAIL pass_read got %02h expected A5", cpuDataIn);
        end
        checks++;
        if (mem[16'hC123] !== 8'hA5) begin
            errors++; $display("FAIL pass_mem got %02h expected A5", mem[16'hC123]);
        end
        checks++;
        if (dmaActive !== 1'b0) begin
            errors++; $display("FAIL pass_dmaActive got %b expected 0", dmaActive);
        end
    endtask

    task automatic test_full_copy();
        int n;
        logic [7:0] exp;
        for (int i = 0; i < 160; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
        mem[16'hFEA0] = 8'h66;
        cpu_trigger(8'hC0);
        wait_idle(n);
        checks++;
        if (n != 321) begin
            errors++; $display("FAIL full_busy_cycles got %0d expected 321", n);
        end
        for (int i = 0; i < 160; i++) begin
            exp = 8'(i) ^ 8'h5A;
            checks++;
            if (mem[16'hFE00 + 16'(i)] !== exp) begin
                errors++; $display("FAIL full_oam[%0d] got %02h expected %02h", i, mem[16'hFE00 + 16'(i)], exp);
            end
        end
        checks++;
        if (mem[16'hFEA0] !== 8'h66) begin
            errors++; $display("FAIL full_past_end got %02h expected 66", mem[16'hFEA0]);
        end
    endtask

    task automatic test_fence();
        int n;
        mem[16'h0150] = 8'h42;
        mem[16'hD000] = 8'h11;
        cpu_trigger(8'hC0);
        repeat (4) step();
        cpuAddress = 16'h0150;
        step();
        checks++;
        if (cpuDataIn !== 8'hFF) begin
            errors++; $display("FAIL fence_read got %02h expected FF", cpuDataIn);
        end
        cpuAddress     = 16'hD000;
        cpuDataOut     = 8'h77;
        cpuWriteEnable = 1'b1;
        #1;
        checks++;
        if (memWriteEnable !== 1'b0 || memAddress !== 16'hC002) begin
            errors++;
            $display("FAIL fence_bus got we=%b addr=%04h expected we=0 addr=C002", memWriteEnable, memAddress);
        end
        step();
        cpuAddress     = 16'hFF46;
        cpuDataOut     = 8'h00;
        cpuWriteEnable = 1'b0;
        step();
        idle_bus();
        checks++;
        if (cpuDataIn !== 8'hC0) begin
            errors++; $display("FAIL fence_reg_readback got %02h expected C0", cpuDataIn);
        end
        wait_idle(n);
        checks++;
        if (n != 314) begin
            errors++; $display("FAIL fence_remaining_cycles got %0d expected 314", n);
        end
        checks++;
        if (mem[16'hD000] !== 8'h11) begin
            errors++; $display("FAIL fence_write_dropped got %02h expected 11", mem[16'hD000]);
        end
    endtask

    task automatic test_restart();
        int n;
        logic [7:0] exp;
        for (int i = 0; i < 160; i++) mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA3;
        cpu_trigger(8'hC0);
        repeat (81) step();
        checks++;
        if (memAddress !== 16'hC028) begin
            errors++; $display("FAIL restart_pre_addr got %04h expected C028", memAddress);
        end
        cpu_trigger(8'hD0);
        wait_idle(n);
        checks++;
        if (n != 321) begin
            errors++; $display("FAIL restart_busy_cycles got %0d expected 321", n);
        end
        for (int i = 0; i < 160; i++) begin
            exp = 8'(i) ^ 8'hA3;
            checks++;
            if (mem[16'hFE00 + 16'(i)] !== exp) begin
                errors++; $display("FAIL restart_oam[%0d] got %02h expected %02h", i, mem[16'hFE00 + 16'(i)], exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'hEE;
        cpu_trigger(8'hC0);
        repeat (162) step();
        checks++;
        if (memWriteEnable !== 1'b1 || memAddress !== 16'hFE50) begin
            errors++;
            $display("FAIL rstmid_pre got we=%b addr=%04h expected we=1 addr=FE50", memWriteEnable, memAddress);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (memWriteEnable !== 1'b0 || dmaActive !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got we=%b active=%b expected we=0 active=0", memWriteEnable, dmaActive);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        cpuAddress     = 16'hC300;
        cpuDataOut     = 8'h3C;
        cpuWriteEnable = 1'b1;
        step();
        cpuWriteEnable = 1'b0;
        step();
        idle_bus();
        checks++;
        if (cpuDataIn !== 8'h3C) begin
            errors++; $display("FAIL rstmid_passthru got %02h expected 3C", cpuDataIn);
        end
        for (int i = 0; i < 160; i++) begin
            exp = (i < 80) ? (8'(i) ^ 8'h5A) : 8'hEE;
            checks++;
            if (mem[16'hFE00 + 16'(i)] !== exp) begin
                errors++; $display("FAIL rstmid_oam[%0d] got %02h expected %02h", i, mem[16'hFE00 + 16'(i)], exp);
            end
        end
    endtask

    task automatic test_boundary();
        int n;
        logic [7:0] exp;
        for (int i = 0; i < 160; i++) begin
            mem[16'hFF00 + 16'(i)] = 8'h30 + 8'(i);
            mem[16'h0000 + 16'(i)] = 8'h99;
        end
        cpu_trigger(8'hFF);
        wait_idle(n);
        checks++;
        if (n != 321) begin
            errors++; $display("FAIL boundary_busy_cycles got %0d expected 321", n);
        end
        for (int i = 0; i < 160; i++) begin
            exp = 8'h30 + 8'(i);
            checks++;
            if (mem[16'hFE00 + 16'(i)] !== exp) begin
                errors++; $display("FAIL boundary_oam[%0d] got %02h expected %02h", i, mem[16'hFE00 + 16'(i)], exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_pass_through();
        test_full_copy();
        test_fence();
        test_restart();
        test_reset_mid();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_bus.md
Name: oam_dma_bus

Overview:
- Bus interposer between the CPU core and the shared 64 KiB memory bus; owns the OAM DMA engine triggered by a CPU write to 0xFF46.
- Idle: transparent pass-through of CPU address/data/write-enable.
- While a DMA is active: copies 160 bytes from {src,8'h00} to 0xFE00 and fences off CPU accesses.
- Memory bus has 1-cycle registered read latency: data for the address driven in cycle t appears on memDataIn in cycle t+1.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU address that triggers DMA and holds the source high byte.
- DEST_BASE, 16'hFE00, OAM destination base.
- LENGTH, 160, bytes per transfer; index counter width = $clog2(LENGTH).
- START_DELAY, 1, idle cycles between trigger and first DMA read.

Ports:
- clk, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- cpuAddress, in, 16, CPU bus address.
- cpuDataOut, in, 8, CPU write data.
- cpuWriteEnable, in, 1, 1 = write, 0 = read.
- cpuDataIn, out, 8, read data to the CPU, same latency as memory.
- memAddress, out, 16, memory bus address.
- memDataOut, out, 8, memory write data.
- memDataIn, in, 8, memory read data (1-cycle latency).
- memWriteEnable, out, 1, memory write strobe.
- dmaActive, out, 1, high in every non-IDLE state.

Behaviour:
- Reset (async): state IDLE, index 0, srcHi 8'h00, cpuBlocked 0, regReadPending 0, dmaActive 0. Combinational outputs then follow IDLE pass-through.
- State machine:
  - IDLE -> START on a CPU write to DMA_REG_ADDR.
  - START stays for START_DELAY cycles, then -> READ.
  - READ -> WRITE.
  - WRITE -> READ while index < LENGTH-1, otherwise -> IDLE.
- Trigger:
  - A CPU write to DMA_REG_ADDR latches srcHi <= cpuDataOut and index <= 0.
  - In IDLE the write is also forwarded to memory.
- IDLE: memAddress = cpuAddress, memDataOut = cpuDataOut, memWriteEnable = cpuWriteEnable.
- READ: memAddress = {srcHi, index[7:0]}, memWriteEnable = 0.
- WRITE:
  - memAddress = DEST_BASE + index, memDataOut = memDataIn, memWriteEnable = 1.
  - index increments at the end of WRITE.
- START: memAddress = cpuAddress, memWriteEnable = 0; the CPU is still fenced.
- Timing: one byte per 2 cycles; total busy time = START_DELAY + 2*LENGTH cycles (321 with defaults). dmaActive falls in the cycle after the last WRITE.
- CPU fence (all non-IDLE states):
  - CPU writes are dropped, except writes to DMA_REG_ADDR.
  - CPU reads return 8'hFF. cpuBlocked is registered at the CPU read cycle, so the 8'hFF appears one cycle later, aligned with memory latency.
- Register readback: a CPU read of DMA_REG_ADDR in any state returns srcHi, via registered regReadPending and the same 1-cycle latency.
- cpuDataIn mux priority: regReadPending (srcHi), then cpuBlocked (8'hFF), then memDataIn.
- Restart: a CPU write to DMA_REG_ADDR while active reloads srcHi, clears index and returns to START. The bytes already copied stay in OAM.
- Simultaneous events: a trigger in the same cycle as the last WRITE is a restart; that final WRITE still completes.
- Source addresses: srcHi is used unmodified (no echo mapping). The source address wraps within the page via the 8-bit index.
- Reset mid-transfer: the engine aborts immediately to IDLE, leaving a partial copy. No write strobe is asserted after reset asserts.

Decomposition:
- Shared package (gb_bus_pkg):
  - DMA state enum (IDLE, START, READ, WRITE).
  - Memory map constants: DMA_REG_ADDR, DEST_BASE, OAM_END 16'hFE9F, OPEN_BUS 8'hFF.
- Single module; no sub-module required. The state/index counter is small enough to stay inline.

Test Plan:
- Pass-through: with no DMA, a CPU write of 8'hA5 to 0xC123 and then a read of 0xC123 -> memory[0xC123] = 8'hA5; cpuDataIn = 8'hA5 one cycle after the read address. dmaActive stays 0.
- Full copy: preload memory[0xC000+i] = i^8'h5A, then CPU writes 8'hC0 to 0xFF46 -> dmaActive high for exactly 321 cycles; memory[0xFE00+i] = i^8'h5A for i = 0..159; memory[0xFEA0] unchanged.
- Fence: during DMA the CPU reads 0x0150 and writes 8'h77 to 0xD000 -> cpuDataIn = 8'hFF one cycle later; memory[0xD000] unchanged. A read of 0xFF46 returns 8'hC0.
- Restart: at index 40, the CPU writes 8'hD0 to 0xFF46 -> index restarts at 0. Final OAM matches the 0xD000 page; dmaActive lasts 321 cycles from the restart write.
- Reset mid-operation: assert reset at index 80 (asynchronously, between clock edges) -> memWriteEnable and dmaActive are 0 immediately. After release, CPU pass-through works; OAM[0..79] copied, OAM[80..159] unchanged.
- Boundary: srcHi = 8'hFF with memory[0xFF00+i] = 8'h30+i -> OAM[i] = 8'h30+i for i < 160. The last source address is 0xFF9F; no wrap into 0x0000.
